// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_ctrl_pkg                                             |
// | Purpose  : Shared types and constants for the RV32IM pipeline stall      |
// |            controller: FSM state encoding, the NOP instruction used by   |
// |            flushed stage registers, default parameters, and a packed     |
// |            control-word type with builder functions for each output      |
// |            pattern the controller can produce.                           |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   // addi x0, x0, 0 -- what a stage register loads when its FLUSH is high
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam int MDU_TIMEOUT_DEFAULT = 64;
   localparam int CNT_W_DEFAULT       = 32;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
   } ctrl_t;

   // Free-running pipe: everything advances, nothing flushed.
   function automatic ctrl_t ctrl_run();
      ctrl_t c;
      c           = '0;
      c.pc_en     = 1'b1;
      c.if_id_en  = 1'b1;
      c.id_ex_en  = 1'b1;
      c.ex_mem_en = 1'b1;
      c.mem_wb_en = 1'b1;
      return c;
   endfunction

   // Whole pipe frozen (data memory not ready).
   function automatic ctrl_t ctrl_freeze();
      ctrl_t c;
      c = '0;
      return c;
   endfunction

   // Front end and EX held; a NOP is injected into EX/MEM so the
   // back end keeps draining. Shared by load-use bubbles and MDU stalls.
   function automatic ctrl_t ctrl_bubble();
      ctrl_t c;
      c              = '0;
      c.ex_mem_en    = 1'b1;
      c.mem_wb_en    = 1'b1;
      c.ex_mem_flush = 1'b1;
      return c;
   endfunction

   // Taken branch: squash the two younger wrong-path instructions.
   function automatic ctrl_t ctrl_branch();
      ctrl_t c;
      c             = ctrl_run();
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_stall_controller_if                                  |
// | Purpose  : Hazard-request / stage-control bundle between the pipeline    |
// |            datapath and the stall controller.                            |
// | Ports    : requests  BUBBLE_REQ, BRANCH_TAKEN, MDU_START, MDU_DONE,      |
// |                      DMEM_BUSY  (pipeline -> controller)                 |
// |            controls  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,    |
// |                      IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH              |
// |                      (controller -> pipeline)                            |
// |            modports: master = pipeline side, slave = controller side     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface pipeline_stall_controller_if;

   logic BUBBLE_REQ;
   logic BRANCH_TAKEN;
   logic MDU_START;
   logic MDU_DONE;
   logic DMEM_BUSY;

   logic PC_EN;
   logic IF_ID_EN;
   logic ID_EX_EN;
   logic EX_MEM_EN;
   logic MEM_WB_EN;
   logic IF_ID_FLUSH;
   logic ID_EX_FLUSH;
   logic EX_MEM_FLUSH;

   modport master (
      output BUBBLE_REQ, BRANCH_TAKEN, MDU_START, MDU_DONE, DMEM_BUSY,
      input  PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
      input  IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH
   );

   modport slave (
      input  BUBBLE_REQ, BRANCH_TAKEN, MDU_START, MDU_DONE, DMEM_BUSY,
      output PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN,
      output IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sat_counter                                                   |
// | Purpose  : Up-counter that sticks at all-ones instead of wrapping.       |
// | Ports    : CLK, RESET (sync, active-high)                                |
// |            inc    - add one this cycle (ignored once saturated)          |
// |            clear  - synchronous clear                                    |
// |            count  - current value, CNT_W bits                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge CLK) begin
      if (RESET || clear) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_stall_controller                                     |
// | Purpose  : Arbitrates hazard requests for a 5-stage RV32IM pipeline and  |
// |            drives per-stage register enables and flushes. Multi-cycle    |
// |            MDU and data-memory stalls are tracked by a small FSM; a      |
// |            saturating counter records stalled cycles and a sticky flag   |
// |            reports an MDU operation that never completes.                |
// | Ports    : CLK, RESET        clock, sync active-high reset               |
// |            hz (slave)        hazard requests in, stage controls out      |
// |            STALL_CYCLES      cycles with PC_EN=0, saturating             |
// |            ERR_MDU_TIMEOUT   sticky MDU timeout flag                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipeline_stall_controller
   import pipeline_ctrl_pkg::*;
#(
   parameter int MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
   parameter int CNT_W       = CNT_W_DEFAULT
) (
   input  logic                        CLK,
   input  logic                        RESET,
   pipeline_stall_controller_if.slave  hz,
   output logic [CNT_W-1:0]            STALL_CYCLES,
   output logic                        ERR_MDU_TIMEOUT
);

   localparam int              MC_W    = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [MC_W-1:0] MC_LAST = MC_W'(MDU_TIMEOUT - 1);

   state_t            state;
   state_t            state_nxt;
   state_t            ret_state;    // where MEM_WAIT resumes once memory is ready
   state_t            ret_nxt;
   state_t            eff_state;    // state whose decode applies when memory is ready
   ctrl_t             ctrl;
   logic              mdu_clear;
   logic              mdu_active;
   logic              mdu_release;
   logic [MC_W-1:0]   mdu_cnt;
   logic              stall_inc;

   // A MEM_WAIT that ends this cycle behaves exactly like the state it froze,
   // so every decode below works on the effective state.
   always_comb begin
      eff_state = (state == MEM_WAIT) ? ret_state : state;
   end

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= RUN;
         ret_state <= RUN;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and output decode, priority DMEM > MDU > bubble > branch
   // ---------------------------------------------------------------------
   always_comb begin
      ctrl      = ctrl_run();
      state_nxt = eff_state;
      ret_nxt   = ret_state;
      mdu_clear = 1'b0;

      if (RESET) begin
         state_nxt = RUN;
         ret_nxt   = RUN;
      end else if (hz.DMEM_BUSY) begin
         ctrl      = ctrl_freeze();
         state_nxt = MEM_WAIT;
         ret_nxt   = eff_state;
      end else begin
         case (eff_state)
            MDU_WAIT: begin
               // Bubble/branch requests are ignored: EX is frozen and will
               // present them again after the MDU result moves on.
               if (hz.MDU_DONE) begin
                  state_nxt = RUN;
               end else begin
                  ctrl = ctrl_bubble();
               end
            end
            default: begin
               if (hz.MDU_START) begin
                  // Single-cycle MUL finishing immediately needs no stall.
                  if (!hz.MDU_DONE) begin
                     ctrl      = ctrl_bubble();
                     state_nxt = MDU_WAIT;
                     mdu_clear = 1'b1;
                  end
               end else if (hz.BUBBLE_REQ) begin
                  // Wins over a simultaneous branch: the branch operand may
                  // depend on the load and is re-resolved next cycle.
                  ctrl = ctrl_bubble();
               end else if (hz.BRANCH_TAKEN) begin
                  ctrl = ctrl_branch();
               end
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // MDU watchdog: keeps counting while a memory stall freezes an MDU wait
   // ---------------------------------------------------------------------
   always_comb begin
      mdu_active  = !RESET && (eff_state == MDU_WAIT);
      mdu_release = mdu_active && !hz.DMEM_BUSY && hz.MDU_DONE;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         mdu_cnt         <= '0;
         ERR_MDU_TIMEOUT <= 1'b0;
      end else begin
         if (mdu_clear) begin
            mdu_cnt <= '0;
         end else if (mdu_active && (mdu_cnt != MC_LAST)) begin
            mdu_cnt <= mdu_cnt + 1'b1;
         end
         if (mdu_active && !mdu_release && (mdu_cnt == MC_LAST)) begin
            ERR_MDU_TIMEOUT <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stall-cycle performance counter
   // ---------------------------------------------------------------------
   always_comb begin
      stall_inc = !RESET && !ctrl.pc_en;
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (stall_inc),
      .clear (1'b0),
      .count (STALL_CYCLES)
   );

   // ---------------------------------------------------------------------
   // Drive the stage controls
   // ---------------------------------------------------------------------
   always_comb begin
      hz.PC_EN        = ctrl.pc_en;
      hz.IF_ID_EN     = ctrl.if_id_en;
      hz.ID_EX_EN     = ctrl.id_ex_en;
      hz.EX_MEM_EN    = ctrl.ex_mem_en;
      hz.MEM_WB_EN    = ctrl.mem_wb_en;
      hz.IF_ID_FLUSH  = ctrl.if_id_flush;
      hz.ID_EX_FLUSH  = ctrl.id_ex_flush;
      hz.EX_MEM_FLUSH = ctrl.ex_mem_flush;
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipeline_stall_controller                                  |
// | Purpose  : Self-checking bench. A cycle-by-cycle table of inputs and     |
// |            expected controls/counters drives the main instance           |
// |            (MDU_TIMEOUT=8); a second instance with a 3-bit counter       |
// |            covers stall-counter saturation.                              |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipeline_stall_controller;

   logic        CLK;
   logic        rst;
   logic        sat_rst;
   logic [31:0] stall_cycles;
   logic        err_to;
   logic [2:0]  sat_cycles;
   logic        sat_err;

   int total = 0;
   int bad   = 0;

   pipeline_stall_controller_if hz  ();
   pipeline_stall_controller_if shz ();

   pipeline_stall_controller #(
      .MDU_TIMEOUT (8),
      .CNT_W       (32)
   ) dut (
      .CLK             (CLK),
      .RESET           (rst),
      .hz              (hz),
      .STALL_CYCLES    (stall_cycles),
      .ERR_MDU_TIMEOUT (err_to)
   );

   pipeline_stall_controller #(
      .MDU_TIMEOUT (8),
      .CNT_W       (3)
   ) dut_sat (
      .CLK             (CLK),
      .RESET           (sat_rst),
      .hz              (shz),
      .STALL_CYCLES    (sat_cycles),
      .ERR_MDU_TIMEOUT (sat_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // en = {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}; fl = {IF_ID, ID_EX, EX_MEM}
   localparam logic [4:0] A  = 5'b11111;
   localparam logic [4:0] N  = 5'b00000;
   localparam logic [4:0] S  = 5'b00011;
   localparam logic [2:0] F0 = 3'b000;
   localparam logic [2:0] FB = 3'b110;
   localparam logic [2:0] FX = 3'b001;

   typedef struct {
      bit         rst, bub, br, ms, md, db;
      logic [4:0] en;
      logic [2:0] fl;
      int         cnt;
      bit         err;
      bit         chk;   // counters are checked only once reset has settled
   } vec_t;

   vec_t vt[$];
   vec_t exp_q[$];

   task automatic add(input bit r, b, br, ms, md, db,
                      input logic [4:0] en, input logic [2:0] fl,
                      input int cnt, input bit err, input bit chk);
      vec_t v;
      v.rst = r; v.bub = b; v.br = br; v.ms = ms; v.md = md; v.db = db;
      v.en = en; v.fl = fl; v.cnt = cnt; v.err = err; v.chk = chk;
      vt.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] get_en();
      return {hz.PC_EN, hz.IF_ID_EN, hz.ID_EX_EN, hz.EX_MEM_EN, hz.MEM_WB_EN};
   endfunction

   function automatic logic [2:0] get_fl();
      return {hz.IF_ID_FLUSH, hz.ID_EX_FLUSH, hz.EX_MEM_FLUSH};
   endfunction

   initial begin
      vec_t e;
      rst = 1'b1; sat_rst = 1'b1;
      hz.BUBBLE_REQ = 0; hz.BRANCH_TAKEN = 0; hz.MDU_START = 0; hz.MDU_DONE = 0; hz.DMEM_BUSY = 0;
      shz.BUBBLE_REQ = 0; shz.BRANCH_TAKEN = 0; shz.MDU_START = 0; shz.MDU_DONE = 0; shz.DMEM_BUSY = 0;

      //   rst bub br ms md db  en  fl  cnt err chk
      add(1, 0, 0, 0, 0, 0, A, F0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, A, F0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, A, F0, 0, 0, 1);   // idle after reset
      add(0, 1, 0, 0, 0, 0, S, FX, 0, 0, 1);   // load-use bubble
      add(0, 0, 0, 0, 0, 0, A, F0, 1, 0, 1);
      add(0, 1, 1, 0, 0, 0, S, FX, 1, 0, 1);   // bubble beats branch
      add(0, 0, 1, 0, 0, 0, A, FB, 2, 0, 1);   // branch re-resolves
      add(0, 0, 0, 0, 0, 0, A, F0, 2, 0, 1);
      add(0, 0, 0, 1, 0, 0, S, FX, 2, 0, 1);   // DIV start
      add(0, 0, 0, 0, 0, 0, S, FX, 3, 0, 1);
      add(0, 0, 1, 0, 0, 0, S, FX, 4, 0, 1);   // branch ignored in MDU_WAIT
      add(0, 1, 0, 0, 0, 0, S, FX, 5, 0, 1);   // bubble ignored in MDU_WAIT
      add(0, 0, 0, 0, 0, 0, S, FX, 6, 0, 1);
      add(0, 0, 0, 0, 1, 0, A, F0, 7, 0, 1);   // release
      add(0, 0, 0, 0, 0, 0, A, F0, 7, 0, 1);
      add(0, 0, 0, 1, 1, 0, A, F0, 7, 0, 1);   // single-cycle MUL
      add(0, 0, 0, 0, 0, 0, A, F0, 7, 0, 1);
      add(0, 0, 0, 1, 0, 0, S, FX, 7, 0, 1);   // MDU then memory stall
      add(0, 0, 0, 0, 0, 0, S, FX, 8, 0, 1);
      add(0, 0, 0, 0, 0, 1, N, F0, 9, 0, 1);
      add(0, 0, 1, 0, 0, 1, N, F0, 10, 0, 1);
      add(0, 0, 0, 0, 0, 1, N, F0, 11, 0, 1);
      add(0, 0, 0, 0, 0, 0, S, FX, 12, 0, 1);  // back in MDU_WAIT
      add(0, 0, 0, 0, 1, 0, A, F0, 13, 0, 1);
      add(0, 0, 0, 0, 0, 0, A, F0, 13, 0, 1);
      add(0, 0, 0, 1, 0, 1, N, F0, 13, 0, 1);  // DMEM beats MDU start
      add(0, 0, 0, 1, 0, 0, S, FX, 14, 0, 1);  // start re-presented
      add(0, 0, 0, 0, 1, 0, A, F0, 15, 0, 1);
      add(0, 0, 1, 0, 0, 1, N, F0, 15, 0, 1);  // DMEM beats branch
      add(0, 0, 1, 0, 0, 0, A, FB, 16, 0, 1);
      add(0, 0, 0, 0, 0, 0, A, F0, 16, 0, 1);
      add(0, 0, 0, 1, 0, 0, S, FX, 16, 0, 1);  // MDU that never finishes
      for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, S, FX, 17 + i, 0, 1);
      add(0, 0, 0, 0, 0, 0, S, FX, 25, 1, 1);  // timeout flagged
      add(0, 0, 0, 0, 0, 0, S, FX, 26, 1, 1);
      add(0, 0, 0, 0, 1, 0, A, F0, 27, 1, 1);  // sticky after release
      add(0, 0, 0, 0, 0, 0, A, F0, 27, 1, 1);
      add(1, 0, 0, 0, 0, 0, A, F0, 27, 1, 1);
      add(0, 0, 0, 0, 0, 0, A, F0, 0, 0, 1);   // reset cleared all
      add(0, 0, 0, 1, 0, 0, S, FX, 0, 0, 1);
      add(1, 0, 0, 1, 0, 0, A, F0, 1, 0, 1);   // reset overrides a stall
      add(0, 0, 0, 0, 0, 0, A, F0, 0, 0, 1);

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge CLK);
         rst = vt[i].rst;
         hz.BUBBLE_REQ = vt[i].bub; hz.BRANCH_TAKEN = vt[i].br;
         hz.MDU_START = vt[i].ms; hz.MDU_DONE = vt[i].md; hz.DMEM_BUSY = vt[i].db;
         exp_q.push_back(vt[i]);
         #2;
         e = exp_q.pop_front();
         check($sformatf("row%0d_en", i), 32'(get_en()), 32'(e.en));
         check($sformatf("row%0d_flush", i), 32'(get_fl()), 32'(e.fl));
         if (e.chk) begin
            check($sformatf("row%0d_stall_cycles", i), stall_cycles, 32'(e.cnt));
            check($sformatf("row%0d_err", i), 32'(err_to), 32'(e.err));
         end
      end

      // Saturation: 3-bit counter under a held stall stops at 7.
      @(negedge CLK);
      sat_rst = 1'b0;
      shz.BUBBLE_REQ = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #2;
         check($sformatf("sat%0d_count", i), 32'(sat_cycles), (i < 7) ? 32'(i) : 32'd7);
         check($sformatf("sat%0d_pc_en", i), 32'(shz.PC_EN), 32'd0);
         @(negedge CLK);
      end
      shz.BUBBLE_REQ = 1'b0;
      #2;
      check("sat_hold_count", 32'(sat_cycles), 32'd7);
      check("sat_hold_pc_en", 32'(shz.PC_EN), 32'd1);
      @(negedge CLK);
      #2;
      check("sat_idle_count", 32'(sat_cycles), 32'd7);
      check("sat_err", 32'(sat_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumer end of the hazard-request interface. Takes the load-use BUBBLE request, EX-stage branch redirects, multi-cycle M-extension (MUL/DIV) busy and data-memory wait.
- Produces per-stage register enables and flushes for the 5-stage RV32IM pipeline.
- Arbitrates simultaneous requests and tracks multi-cycle stalls with a small FSM.
- Keeps a saturating stall-cycle performance counter and a sticky MDU timeout flag.

Parameters:
- MDU_TIMEOUT, 64, max cycles in MDU_WAIT before ERR_MDU_TIMEOUT sets.
- CNT_W, 32, width of STALL_CYCLES counter.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RESET  input  1  synchronous, active-high.
- BUBBLE_REQ  input  1  load-use hazard; load in MEM, dependent instruction in EX.
- BRANCH_TAKEN  input  1  EX resolved taken branch/jump.
- MDU_START  input  1  MUL/DIV op entered EX this cycle.
- MDU_DONE  input  1  MDU result valid this cycle.
- DMEM_BUSY  input  1  data memory not ready; whole pipe must hold.
- PC_EN  output  1  PC update enable.
- IF_ID_EN  output  1  IF/ID register enable.
- ID_EX_EN  output  1  ID/EX register enable.
- EX_MEM_EN  output  1  EX/MEM register enable.
- MEM_WB_EN  output  1  MEM/WB register enable.
- IF_ID_FLUSH  output  1  load NOP into IF/ID.
- ID_EX_FLUSH  output  1  load NOP into ID/EX.
- EX_MEM_FLUSH  output  1  load NOP into EX/MEM.
- STALL_CYCLES  output  CNT_W  saturating count of cycles with PC_EN=0.
- ERR_MDU_TIMEOUT  output  1  sticky MDU timeout flag.

Behaviour:
- All control outputs are combinational decode of registered state plus current inputs. Stalls take effect in the same cycle as the request.
- FSM states: RUN, MDU_WAIT, MEM_WAIT. Reset: state=RUN, STALL_CYCLES=0, ERR_MDU_TIMEOUT=0, MDU counter=0.
- During RESET high, outputs are forced to: all EN=1, all FLUSH=0.
- Default in RUN: all EN=1, all FLUSH=0.
- Priority per cycle, highest first: DMEM_BUSY > MDU (MDU_WAIT or MDU_START) > BUBBLE_REQ > BRANCH_TAKEN.
- DMEM_BUSY=1, any state:
  - all EN=0, all FLUSH=0.
  - Next state MEM_WAIT; the state to return to is remembered (RUN or MDU_WAIT).
  - The MDU counter keeps counting.
- MEM_WAIT with DMEM_BUSY=0: resume the remembered state in the same cycle; outputs are decoded as that state.
- MDU_START in RUN, no DMEM_BUSY:
  - PC_EN=IF_ID_EN=ID_EX_EN=0; EX_MEM_EN=1, EX_MEM_FLUSH=1; MEM_WB_EN=1.
  - Next state MDU_WAIT; counter cleared.
  - Exception: if MDU_DONE=1 in the same cycle (single-cycle MUL), no stall and state stays RUN.
- MDU_WAIT:
  - Outputs as for MDU_START.
  - On MDU_DONE=1: this cycle all EN=1, EX_MEM_FLUSH=0 so the result advances; next state RUN.
  - Counter increments each cycle. At count==MDU_TIMEOUT-1 without MDU_DONE, ERR_MDU_TIMEOUT sets; it clears only on RESET.
  - The FSM stays in MDU_WAIT after a timeout.
- BUBBLE_REQ in RUN: PC_EN=IF_ID_EN=ID_EX_EN=0, EX_MEM_FLUSH=1, MEM_WB_EN=1. The bubble lasts exactly one cycle and there is no state change; the requester deasserts next cycle.
- BUBBLE_REQ with BRANCH_TAKEN simultaneous: bubble wins and BRANCH_TAKEN is ignored, because a branch operand depending on the load is not yet valid. The branch re-resolves next cycle.
- BRANCH_TAKEN alone in RUN: all EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1.
- BRANCH_TAKEN or BUBBLE_REQ during MDU_WAIT or MEM_WAIT: ignored. The EX instruction is frozen and re-presents them.
- A FLUSH is asserted only when the corresponding EN=1.
- STALL_CYCLES increments every cycle with PC_EN=0, outside RESET. It saturates at all-ones with no wrap.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encoding: RUN=2'd0, MDU_WAIT=2'd1, MEM_WAIT=2'd2.
  - the NOP instruction constant 32'h00000013, for stage registers honoring FLUSH.
  - MDU_TIMEOUT default.
- One natural sub-module, sat_counter (CNT_W, inc, clear), used for STALL_CYCLES.
- The MDU counter stays inline.

Test Plan:
- Reset, then idle: RESET=1 for 2 cycles, then all requests 0 -> all EN=1, FLUSH=0, STALL_CYCLES=0, ERR=0.
- Load-use: BUBBLE_REQ=1 for one cycle -> PC_EN/IF_ID_EN/ID_EX_EN=0 and EX_MEM_FLUSH=1 for exactly 1 cycle; STALL_CYCLES=1.
- Bubble+branch simultaneous -> bubble outputs only, IF_ID_FLUSH=0. Next cycle BRANCH_TAKEN=1 -> IF_ID_FLUSH=ID_EX_FLUSH=1 and all EN=1.
- DIV: MDU_START, then MDU_DONE 5 cycles later -> 5 stalled cycles with EX_MEM_FLUSH=1, then a release cycle with all EN=1; STALL_CYCLES=5.
- DMEM_BUSY=1 for 3 cycles in the middle of MDU_WAIT -> all EN=0 for 3 cycles, then return to MDU_WAIT. MDU_DONE then releases; no flush while frozen.
- Timeout: MDU_TIMEOUT=8, MDU_START with no MDU_DONE -> ERR_MDU_TIMEOUT=1 after 8 cycles, stays 1 until RESET. Also preload STALL_CYCLES near all-ones and hold a stall -> counter saturates.
